timer_counter_adv: RTL and testbench

Parametrised general-purpose timer counter for the timer IP, succeeding the fixed 64-bit up-counter. It adds configurable width, a programmable prescaler, up/down direction, a reload value applied at terminal count, one-shot and periodic modes, and a compare-match pulse. It sits between counter control (enable, mode) and the register block (clear, CPU load, reload/compare values, status pulses).

---
 rtl/timer_counter_adv.sv | 63 ++++++
 tb/tb_timer_counter_adv.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/timer_counter_adv.sv
// timer_counter_adv: prescaled up/down timer with reload, one-shot/periodic modes and compare match
module timer_counter_adv #(
   parameter int CNT_W = 64,
   parameter int DIV_W = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             cnt_en,
   input  logic             cnt_clr,
   input  logic             ld_en,
   input  logic [CNT_W-1:0] ld_val,
   input  logic [CNT_W-1:0] rld_val,
   input  logic [CNT_W-1:0] cmp_val,
   input  logic             dir,
   input  logic             oneshot,
   input  logic [DIV_W-1:0] div_val,
   output logic [CNT_W-1:0] cnt,
   output logic             tick,
   output logic             ovf,
   output logic             cmp_match,
   output logic             upd,
   output logic             running
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [DIV_W-1:0] div_cnt, div_nx;
   logic [CNT_W-1:0] cnt_nx, step;
   logic wr, adv, tk, term;
   always_comb begin
      wr       = cnt_clr || ld_en;
      adv      = state == RUN && cnt_en && !wr;
      tk       = adv && div_cnt == div_val;
      term     = dir ? cnt == '0 : &cnt;
      step     = dir ? cnt - CNT_W'(1) : cnt + CNT_W'(1);
      cnt_nx   = cnt_clr ? '0 : ld_en ? ld_val : tk ? (term ? rld_val : step) : cnt;
      div_nx   = wr ? '0 : adv ? (tk ? '0 : div_cnt + DIV_W'(1)) : div_cnt;
      // a clear or load releases a finished one-shot back to IDLE
      state_nx = !cnt_en ? IDLE
               : state == DONE ? (wr ? IDLE : DONE)
               : (tk && term && oneshot) ? DONE : RUN;
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         div_cnt   <= '0;
         cnt       <= '0;
         tick      <= 1'b0;
         ovf       <= 1'b0;
         cmp_match <= 1'b0;
         upd       <= 1'b0;
         running   <= 1'b0;
      end else begin
         state     <= state_nx;
         div_cnt   <= div_nx;
         cnt       <= cnt_nx;
         tick      <= tk;
         ovf       <= tk && term;
         cmp_match <= tk && cnt_nx == cmp_val;
         upd       <= wr || tk;
         running   <= state_nx == RUN;
      end
   end
endmodule

// File: tb/tb_timer_counter_adv.sv
// tb_timer_counter_adv: directed and randomized checks of timer_counter_adv against a behavioural model
module tb_timer_counter_adv;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       en = 1'b0, clr = 1'b0, ld = 1'b0, dir = 1'b0, oneshot = 1'b0;
   logic [7:0] ld_val = '0, rld_val = '0, cmp_val = 8'h80, div_val = '0;
   logic [7:0] cnt;
   logic       tick, ovf, cmp_match, upd, running;
   int         total = 0, bad = 0;
   int         m_cnt, m_div;
   bit         m_run, m_done, e_tick, e_ovf, e_cmp, e_upd;

   timer_counter_adv #(.CNT_W(8), .DIV_W(8)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .cnt_en(en), .cnt_clr(clr), .ld_en(ld),
      .ld_val(ld_val), .rld_val(rld_val), .cmp_val(cmp_val), .dir(dir), .oneshot(oneshot),
      .div_val(div_val), .cnt(cnt), .tick(tick), .ovf(ovf), .cmp_match(cmp_match),
      .upd(upd), .running(running)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_div = 0; m_run = 0; m_done = 0;
      e_tick = 0; e_ovf = 0; e_cmp = 0; e_upd = 0;
   endtask

   task automatic check_all();
      check("cnt", cnt, m_cnt);
      check("tick", tick, e_tick);
      check("ovf", ovf, e_ovf);
      check("cmp_match", cmp_match, e_cmp);
      check("upd", upd, e_upd);
      check("running", running, m_run);
   endtask

   // one clock edge: advance the model from the inputs seen at the edge, then compare
   task automatic step();
      bit finished = 0;
      @(posedge clk);
      e_tick = 0; e_ovf = 0; e_cmp = 0; e_upd = 0;
      if (clr) begin
         m_cnt = 0; m_div = 0; e_upd = 1;
      end else if (ld) begin
         m_cnt = int'(ld_val); m_div = 0; e_upd = 1;
      end else if (m_run && en) begin
         if (m_div == int'(div_val)) begin
            m_div = 0; e_tick = 1; e_upd = 1;
            if ((dir && m_cnt == 0) || (!dir && m_cnt == 255)) begin
               m_cnt = int'(rld_val); e_ovf = 1; finished = oneshot;
            end else
               m_cnt = dir ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
            e_cmp = (m_cnt == int'(cmp_val));
         end else
            m_div = (m_div + 1) % 256;
      end
      if (!en) begin
         m_run = 0; m_done = 0;
      end else if (m_done) begin
         m_done = !(clr || ld); m_run = 0;
      end else if (finished) begin
         m_run = 0; m_done = 1;
      end else
         m_run = 1;
      #1;
      check_all();
   endtask

   initial begin
      int k;
      model_reset();
      #2;
      check_all();
      #5 rst_n = 1'b1;
      // wrap from 0xFD through terminal count with reload 0
      ld_val = 8'hFD; ld = 1; step(); ld = 0;
      en = 1;
      repeat (5) step();
      check("t1_cnt", cnt, 8'h01);
      // prescaler of 4 and pause shift
      en = 0; step(); clr = 1; step(); clr = 0;
      div_val = 3; en = 1; step();
      repeat (12) step();
      check("t2_adv", cnt, 3);
      step();
      en = 0; step(); en = 1; step();
      k = 3;
      while (!tick && k < 20) begin step(); k++; end
      check("t2_shift", k, 6);
      // down one-shot with reload and resume
      en = 0; step();
      div_val = 0; dir = 1; oneshot = 1; rld_val = 8'h10; ld_val = 8'h03;
      ld = 1; step(); ld = 0;
      en = 1; step();
      repeat (4) step();
      check("t3_cnt", cnt, 8'h10);
      check("t3_ovf", ovf, 1);
      check("t3_run", running, 0);
      repeat (3) step();
      check("t3_frozen", cnt, 8'h10);
      en = 0; step(); en = 1; step(); step();
      check("t3_resume", cnt, 8'h0F);
      // compare match on tick only
      oneshot = 0; dir = 0; en = 0; step();
      cmp_val = 8'h05; ld_val = 8'h03; ld = 1; step(); ld = 0;
      en = 1;
      repeat (4) step();
      en = 0; step();
      ld_val = 8'h05; ld = 1; step(); ld = 0;
      check("t4_ld_cmp", cmp_match, 0);
      check("t4_ld_upd", upd, 1);
      // clear, load and a due tick on one edge
      div_val = 2; en = 1; step();
      k = 0;
      while (m_div != int'(div_val) && k < 10) begin step(); k++; end
      check("t5_due", m_div, div_val);
      clr = 1; ld = 1; ld_val = 8'h77; step(); clr = 0; ld = 0;
      check("t5_cnt", cnt, 0);
      check("t5_tick", tick, 0);
      repeat (4) step();
      // asynchronous reset mid-period
      div_val = 3; step(); step();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      #2 rst_n = 1'b1;
      step();
      check("t6_run", running, 1);
      k = 1;
      while (!tick && k < 20) begin step(); k++; end
      check("t6_first_tick", k, 5);
      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         en = $urandom_range(0, 99) < 92;
         clr = $urandom_range(0, 99) < 2;
         ld = $urandom_range(0, 99) < 3;
         ld_val = $urandom_range(0, 1) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 5));
         if ($urandom_range(0, 19) == 0) dir = ~dir;
         if ($urandom_range(0, 19) == 0) oneshot = $urandom_range(0, 2) == 0;
         if ($urandom_range(0, 99) == 0) div_val = 8'($urandom_range(0, 3));
         rld_val = 8'($urandom);
         if ($urandom_range(0, 3) == 0) cmp_val = 8'(dir ? m_cnt - 1 : m_cnt + 1);
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
